// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues fetch requests one at a time, buffers returned
// instructions in a small {pc,inst} queue toward decode, and handles control-flow redirects
// by flushing the queue and dropping any fetch still in flight.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] ifu_pc,
    output logic        ifu_reqValid,
    input  logic        ifu_respValid,
    input  logic [31:0] ifu_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int unsigned     PtrW     = $clog2(DEPTH);
    localparam int unsigned     CntW     = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrain
    } state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     req_pc_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];

    logic        push;
    logic        pop;
    logic [31:0] redirect_tgt;
    logic [31:0] fetch_pc_inc;
    logic        unused_redirect_lsb;

    // Request, push/pop and head-of-queue decode
    always_comb begin
        redirect_tgt = {redirect_pc[31:2], 2'b00};
        fetch_pc_inc = fetch_pc_q + 32'd4;
        // WAIT and DRAIN keep presenting the address that was actually issued
        ifu_pc       = (state_q == StIdle) ? fetch_pc_q : req_pc_q;
        // Gated by reset so the request drops the instant reset asserts
        ifu_reqValid = reset && ((state_q != StIdle) ||
                                 ((count_q < DepthCnt) && !redirect_valid));
        // A response is kept only in IDLE (zero-wait) or WAIT, never during a redirect
        push         = ifu_respValid && !redirect_valid &&
                       (((state_q == StIdle) && ifu_reqValid) || (state_q == StWait));
        out_valid    = (count_q != '0);
        out_pc       = pc_mem[rd_ptr_q];
        out_inst     = inst_mem[rd_ptr_q];
        pop          = out_valid && out_ready;
    end

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Fetch FSM, fetch address and queue pointers/count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                    end else if (ifu_reqValid) begin
                        if (ifu_respValid) begin
                            fetch_pc_q <= fetch_pc_inc;
                        end else begin
                            req_pc_q <= fetch_pc_q;
                            state_q  <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                        // A response arriving with the redirect is dropped right here
                        state_q    <= ifu_respValid ? StIdle : StDrain;
                    end else if (ifu_respValid) begin
                        fetch_pc_q <= fetch_pc_inc;
                        state_q    <= StIdle;
                    end
                end
                StDrain: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_tgt;
                    end
                    if (ifu_respValid) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // A pop in a redirect cycle is still delivered; the flush wins afterwards
            if (redirect_valid) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
                if (push && !pop) begin
                    count_q <= count_q + CntW'(1);
                end else if (pop && !push) begin
                    count_q <= count_q - CntW'(1);
                end
            end
        end
    end

    // Queue storage; never full on push since only one fetch is ever outstanding
    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= ifu_pc;
            inst_mem[wr_ptr_q] <= ifu_inst;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed stimulus with a scoreboard of expected deliveries,
// checked by an independent monitor on every accepted head entry.
module tb_fetch_ctrl;

    localparam logic [31:0] ResetPc = 32'h8000_0000;

    logic        clock;
    logic        reset;
    logic [31:0] ifu_pc;
    logic        ifu_reqValid;
    logic        ifu_respValid;
    logic [31:0] ifu_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    logic        tie_mode;
    logic        resp_force;
    logic [63:0] exp_q[$];
    int          checks;
    int          failures;

    fetch_ctrl #(
        .RESET_PC(ResetPc),
        .DEPTH   (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ifu_pc        (ifu_pc),
        .ifu_reqValid  (ifu_reqValid),
        .ifu_respValid (ifu_respValid),
        .ifu_inst      (ifu_inst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    // Fetch unit model: either zero-wait (response tied to request) or driven by stimulus
    assign ifu_respValid = tie_mode ? ifu_reqValid : resp_force;
    assign ifu_inst      = inst_of(ifu_pc);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc);
        exp_q.push_back({pc, inst_of(pc)});
    endtask

    // Monitor: every accepted head entry must match the next expected one
    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual=%h required=none", out_pc);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("pop_pc", out_pc, e[63:32]);
                check("pop_inst", out_inst, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset mid-cycle; returns 1 time unit after the release edge
    task automatic do_reset();
        reset          = 1'b0;
        tie_mode       = 1'b0;
        resp_force     = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        check("rst_reqValid", 32'(ifu_reqValid), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_ifu_pc", ifu_pc, ResetPc);
        tick();
        tick();
        exp_q.delete();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        #2;

        // Zero-wait fetch: one instruction per cycle
        do_reset();
        tie_mode  = 1'b1;
        out_ready = 1'b1;
        expect_entry(32'h8000_0000);
        expect_entry(32'h8000_0004);
        expect_entry(32'h8000_0008);
        #1;
        check("first_req_valid", 32'(ifu_reqValid), 32'h1);
        check("first_req_pc", ifu_pc, ResetPc);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("zw_out_valid", 32'(out_valid), 32'h1);
            check("zw_out_pc", out_pc, 32'h8000_0000 + 32'(4 * i));
        end
        @(negedge clock);
        #1;
        check("zw_sb_empty", 32'(exp_q.size()), 32'h0);

        // Back-pressure: queue fills at two entries, head stays put
        do_reset();
        tie_mode = 1'b1;
        expect_entry(32'h8000_0000);
        expect_entry(32'h8000_0004);
        tick();
        tick();
        #1;
        check("bp_reqValid_full", 32'(ifu_reqValid), 32'h0);
        check("bp_head_pc", out_pc, 32'h8000_0000);
        tick();
        tick();
        tick();
        #1;
        check("bp_reqValid_hold", 32'(ifu_reqValid), 32'h0);
        check("bp_head_hold", out_pc, 32'h8000_0000);
        out_ready = 1'b1;
        tick();
        tie_mode = 1'b0;
        tick();
        #1;
        check("bp_drained", 32'(out_valid), 32'h0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'h0);

        // Wait states: request held three cycles, then one push
        do_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ws_reqValid", 32'(ifu_reqValid), 32'h1);
            check("ws_ifu_pc", ifu_pc, 32'h8000_0000);
            if (i == 2) resp_force = 1'b1;
            tick();
        end
        resp_force = 1'b0;
        #1;
        check("ws_out_valid", 32'(out_valid), 32'h1);
        check("ws_out_pc", out_pc, 32'h8000_0000);
        check("ws_next_pc", ifu_pc, 32'h8000_0004);
        expect_entry(32'h8000_0000);
        out_ready = 1'b1;
        tick();
        #1;
        check("ws_sb_empty", 32'(exp_q.size()), 32'h0);

        // Redirect in WAIT, response two cycles later is discarded
        do_reset();
        out_ready = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("dr_reqValid", 32'(ifu_reqValid), 32'h1);
        check("dr_held_pc", ifu_pc, 32'h8000_0000);
        check("dr_flushed", 32'(out_valid), 32'h0);
        tick();
        resp_force = 1'b1;
        tick();
        resp_force = 1'b0;
        #1;
        check("dr_discard", 32'(out_valid), 32'h0);
        check("dr_new_req", 32'(ifu_reqValid), 32'h1);
        check("dr_new_pc", ifu_pc, 32'h8000_0100);
        tie_mode = 1'b1;
        expect_entry(32'h8000_0100);
        tick();
        tie_mode = 1'b0;
        #1;
        check("dr_first_pc", out_pc, 32'h8000_0100);
        tick();

        // Redirect coincident with response and pop
        do_reset();
        resp_force = 1'b1;
        expect_entry(32'h8000_0000);
        tick();
        resp_force = 1'b0;
        tick();
        out_ready      = 1'b1;
        resp_force     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        #1;
        check("co_head_pc", out_pc, 32'h8000_0000);
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        #1;
        check("co_out_valid", 32'(out_valid), 32'h0);
        check("co_ifu_pc", ifu_pc, 32'h8000_0200);
        check("co_sb_empty", 32'(exp_q.size()), 32'h0);

        // Reset asserted while waiting with a queued entry
        tick();
        resp_force = 1'b0;
        tick();
        #1;
        check("rw_in_wait_pc", ifu_pc, 32'h8000_0204);
        check("rw_out_valid", 32'(out_valid), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("rw_async_req", 32'(ifu_reqValid), 32'h0);
        check("rw_async_valid", 32'(out_valid), 32'h0);
        check("rw_async_pc", ifu_pc, ResetPc);
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rw_release_req", 32'(ifu_reqValid), 32'h1);
        check("rw_release_pc", ifu_pc, ResetPc);

        // Redirect in IDLE to the top of memory, then wrap to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        check("wr_no_req", 32'(ifu_reqValid), 32'h0);
        tick();
        redirect_valid = 1'b0;
        tie_mode       = 1'b1;
        out_ready      = 1'b1;
        expect_entry(32'hFFFF_FFFC);
        expect_entry(32'h0000_0000);
        #1;
        check("wr_top_pc", ifu_pc, 32'hFFFF_FFFC);
        tick();
        tick();
        tie_mode = 1'b0;
        #1;
        check("wr_zero_head", out_pc, 32'h0000_0000);
        check("wr_next_pc", ifu_pc, 32'h0000_0004);
        tick();
        #1;
        check("wr_sb_empty", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction queue entries; legal values are 2 or 4.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ifu_pc  output  32  fetch address presented to the fetch unit.
REQ-006 SHALL have port ifu_reqValid  output  1  fetch request to the fetch unit.
REQ-007 SHALL have port ifu_respValid  input  1  fetch response valid; may assert in the same cycle as the request.
REQ-008 SHALL have port ifu_inst  input  32  fetched instruction, valid while ifu_respValid is high.
REQ-009 SHALL have port redirect_valid  input  1  one-cycle control-flow redirect (branch, jump, trap).
REQ-010 SHALL have port redirect_pc  input  32  redirect target.
REQ-011 SHALL have port out_valid  output  1  queue head valid toward decode.
REQ-012 SHALL have port out_ready  input  1  decode accepts the head.
REQ-013 SHALL have port out_inst  output  32  head instruction.
REQ-014 SHALL have port out_pc  output  32  head instruction address.

Function
REQ-015 SHALL hold fetch_pc, a queue of DEPTH {pc,inst} entries with count, and FSM states IDLE, WAIT and DRAIN.
REQ-016 SHALL allow at most one outstanding fetch.
REQ-017 In IDLE, SHALL assert ifu_reqValid with ifu_pc=fetch_pc when count<DEPTH and redirect_valid=0; otherwise ifu_reqValid=0.
REQ-018 In IDLE with a request and ifu_respValid=1 in the same cycle, SHALL push {fetch_pc,ifu_inst}, set fetch_pc+=4, and stay IDLE (zero-wait fetch; one instruction per cycle is sustainable).
REQ-019 In IDLE with a request and ifu_respValid=0, SHALL go to WAIT.
REQ-020 In WAIT and DRAIN, SHALL hold ifu_reqValid=1 and ifu_pc stable at the issued address until ifu_respValid.
REQ-021 In WAIT with ifu_respValid=1 and no redirect, SHALL push the entry, set fetch_pc+=4, and go to IDLE.
REQ-022 On redirect_valid in IDLE, SHALL set fetch_pc={redirect_pc[31:2],2'b00}, flush the queue (count=0), and issue no request that cycle.
REQ-023 On redirect_valid in WAIT without a response, SHALL update fetch_pc, flush the queue, and go to DRAIN.
REQ-024 On redirect_valid in WAIT with ifu_respValid=1, SHALL discard the response, update fetch_pc, flush, and go to IDLE.
REQ-025 In DRAIN, SHALL discard the response when ifu_respValid=1 and go to IDLE; a further redirect in DRAIN overwrites fetch_pc and keeps the drain.
REQ-026 out_valid SHALL equal (count!=0); out_inst/out_pc SHALL be the head entry; a pop occurs when out_valid&&out_ready.
REQ-027 A pop in a redirect cycle SHALL still count as delivered; the flush applies after it.
REQ-028 Simultaneous push and pop SHALL leave count unchanged, with pointers wrapping modulo DEPTH.
REQ-029 A push SHALL never find the queue full, because of REQ-016 and REQ-017.
REQ-030 fetch_pc arithmetic SHALL be 32-bit, wrapping from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-031 While reset=0, SHALL hold state IDLE, fetch_pc=RESET_PC, count=0, pointers=0, out_valid=0, ifu_reqValid=0.
REQ-032 A reset assertion mid-fetch SHALL abandon the outstanding request immediately without a drain.
REQ-033 The first request (ifu_pc=RESET_PC) SHALL be issued in the first cycle after reset deassertion.

Verification
REQ-034 Zero-wait fetch: release reset, ifu_respValid tied to ifu_reqValid, out_ready=1 -> out_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles.
REQ-035 Back-pressure: out_ready=0, DEPTH=2 -> exactly 2 entries are pushed, ifu_reqValid drops to 0, and out_pc stays 8000_0000 until out_ready=1.
REQ-036 Wait states: 3-cycle response latency -> ifu_reqValid and ifu_pc=8000_0000 are held stable for 3 cycles, then one push and a return to IDLE.
REQ-037 Redirect in WAIT, response 2 cycles later -> that response is discarded, the queue is empty, and the next request is ifu_pc=redirect_pc (e.g. 8000_0100, or 8000_0100 for an input of 8000_0103).
REQ-038 Redirect coincident with a response and a pop -> the popped entry is delivered, the response is dropped, and out_valid=0 next cycle.
REQ-039 Reset asserted in WAIT -> all outputs reach reset values without a clock edge, and ifu_pc=RESET_PC after release.
